// File: rtl/bcd_count_ctrl.sv
`timescale 1ns/1ps
// Run/pause/step/clear sequencer for a two-digit BCD counter.
// Prescaled tick in RUN, optional stop at a BCD target.
module bcd_count_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [7:0]  LEDR,
  output logic [3:0]  LEDG
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic rst_n;
  assign rst_n = KEY[0];

  logic          unused_sw;
  assign unused_sw = ^SW[15:8];

  logic [2:0]    sync1_q, sync2_q, hist_q;
  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    ledg_q, ledg_d;
  logic          inv_q, inv_d;

  logic [2:0]    ev;
  logic          start_ev, clr_ev, step_ev;
  logic          tgt_bad, hit, tick;
  logic [7:0]    stepped;

  function automatic logic [7:0] bcd_step(
    input logic [7:0] c,
    input logic       dn
  );
    logic [3:0] t, o;
    t = c[7:4];
    o = c[3:0];
    if (!dn) begin
      if (o == 4'd9) begin
        o = 4'd0;
        t = (t == 4'd9) ? 4'd0 : t + 4'd1;
      end else begin
        o = o + 4'd1;
      end
    end else begin
      if (o == 4'd0) begin
        o = 4'd9;
        t = (t == 4'd0) ? 4'd9 : t - 4'd1;
      end else begin
        o = o - 4'd1;
      end
    end
    return {t, o};
  endfunction

  always_comb begin
    ev       = hist_q & ~sync2_q;
    start_ev = ev[0];
    clr_ev   = ev[1];
    step_ev  = ev[2];
    tgt_bad  = (SW[7:4] > 4'd9) || (SW[3:0] > 4'd9);
    inv_d    = tgt_bad;
    stepped  = bcd_step(cnt_q, SW[16]);
    hit      = SW[17] && !tgt_bad && (stepped == SW[7:0]);
    tick     = (state_q == RUN) && (pre_q == LAST);

    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;

    if (clr_ev) begin
      state_d = IDLE;
      cnt_d   = SW[16] ? 8'h99 : 8'h00;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ev) begin
            if (!(SW[17] && tgt_bad)) begin
              state_d = RUN;
              pre_d   = '0;
            end
          end else if (step_ev) begin
            cnt_d = stepped;
            if (hit) state_d = DONE;
          end
        end
        RUN: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            cnt_d = stepped;
            if (hit)           state_d = DONE;
            else if (start_ev) state_d = PAUSE;
          end else if (start_ev) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start_ev) begin
            state_d = RUN;
          end else if (step_ev) begin
            cnt_d = stepped;
            if (hit) state_d = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end

    // LEDG[2:0] mirrors the next state so it lands with the step
    ledg_d = {state_d == DONE, state_d == PAUSE, state_d == RUN};
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      hist_q  <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= 8'h00;
      pre_q   <= '0;
      ledg_q  <= 3'b000;
      inv_q   <= 1'b0;
    end else begin
      sync1_q <= KEY[3:1];
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      ledg_q  <= ledg_d;
      inv_q   <= inv_d;
    end
  end

  assign LEDR = cnt_q;
  assign LEDG = {inv_q, ledg_q};

endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Run-control sequencer for the two-digit BCD counter (00–99) shown on LEDR[7:0]. Replaces manual KEY clocking with a free-running clock, a prescaled count tick, and a run/pause/step/clear state machine with an optional BCD stop target. Sits between the board buttons and switches and the LED display, and owns the counter registers it sequences.

## Interface
- TICK_DIV, 50_000_000: CLOCK_50 cycles per count step in RUN; must be at least 2. Benches use 4.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- KEY  in  4  KEY[0] = reset, asynchronous, active-low. KEY[1] = start/pause, KEY[2] = clear, KEY[3] = single-step; buttons are active-low, released = 1.
- SW  in  18  SW[7:4] = target tens digit, SW[3:0] = target ones digit, SW[16] = direction (0 up, 1 down), SW[17] = stop-at-target enable. Other bits unused.
- LEDR  out  8  count: [7:4] tens BCD, [3:0] ones BCD.
- LEDG  out  4  [0] RUN, [1] PAUSE, [2] DONE, [3] target invalid (either target digit > 9).

## Operation
- Button path: KEY[3:1] → 2-flop synchronizer → history flop; all flops reset to 1. A press event is a single-cycle falling edge of the synchronized level (history = 1, sync = 0). There is no debounce; each clean low pulse yields exactly one event.
- SW bits are treated as quasi-static and used unsynchronized. A change takes effect at the next step.
- Prescaler: 0..TICK_DIV-1, counts only in RUN, wraps to 0. It is zeroed on reset, on clear, and on the IDLE→RUN transition. It holds its value in PAUSE and DONE. A tick is asserted when prescaler = TICK_DIV-1 in RUN.
- Step (from a tick or a step event):
  - Up: ones 9→0 carries into tens; 99→00.
  - Down: ones 0→9 borrows from tens; 00→99.
  - Digits never leave 0–9.
- Match: when SW[17] = 1, the target is valid, and the post-step count equals SW[7:0], the state goes to DONE on the same edge as the step. A match is evaluated only on steps; the count already equalling the target does not trigger DONE.
- FSM states: IDLE, RUN, PAUSE, DONE. Reset → IDLE with count 00.
  - IDLE: start → RUN, except when SW[17] = 1 and the target is invalid, where start is ignored. Step → one step, stay IDLE unless matched.
  - RUN: tick → step. Start → PAUSE. Step events are ignored.
  - PAUSE: start → RUN with the prescaler resumed. Step → one step, or DONE on match.
  - DONE: count frozen; start and step ignored.
  - Any state: clear → IDLE with count 00 if SW[16] = 0, or 99 if SW[16] = 1.
- Priority when events coincide: clear > start > step.
  - In RUN, a tick and a start in the same cycle: the step happens and the state goes to PAUSE. If that step matches, the state goes to DONE instead.
  - Step coincident with start: step is dropped.
- Reset mid-operation: all flops return to reset values immediately, regardless of clock.

## Timing
- Reset values: LEDR = 8'h00, LEDG = 4'b0000, state IDLE, prescaler 0, sync flops 1.
- All outputs are registered. LEDG[2:0] is one-hot from state; LEDG[3] is the registered target-invalid flag, one cycle behind SW.
- Button latency: KEY[i] low sampled at edge E1 → event valid after E2 → state/count update at E3.
- RUN cadence: the first step lands TICK_DIV edges after the edge that entered RUN. Subsequent steps occur every TICK_DIV edges.
- Pause/resume preserves phase: the total RUN cycles between steps is always TICK_DIV.
- A match step and the DONE indication (LEDG[2]) appear on the same edge.

## Test plan
- Reset and start, up count, TICK_DIV = 4: KEY[0] low → LEDR = 00, LEDG = 0000. Press KEY[1] → LEDG = 0001; LEDR = 01 four cycles after the RUN edge, 02 after eight.
- Wrap, both directions: up count reaches 99, next tick → 00. SW[16] = 1 with clear → 99, then 98 ... 00, next tick → 99. The 09→10 carry and 10→09 borrow are checked.
- Stop target: SW[17] = 1, SW[7:0] = 8'h12, up. Count stops at 12 with LEDG = 0100; further start/step presses leave LEDR = 12. Clear → IDLE, 00.
- Target equal to start value: count 00, target 00, run. The count passes 01 ... 99 and enters DONE at 00 after exactly 100 ticks.
- Pause and step: run to 05, press start → PAUSE holds 05. Two KEY[3] presses → 07. Resume; next step lands after the remaining prescaler cycles.
- Priority and invalid target: clear and start pressed together in RUN → IDLE, no RUN. Target 8'h1A with SW[17] = 1 → LEDG[3] = 1 and start ignored. KEY[0] asserted mid-RUN → immediate return to all-zero outputs.
